// File: rtl/ga_palette_regs.sv
// ga_palette_regs - Gate Array register file and raster interrupt generator.
//
// Decodes Z80 OUT writes to the Gate Array port (A15=0, A14=1) and holds the
// 16 pen inks, the border ink, the screen mode and the ROM-disable bits.
// The video generator's current pen is translated to a 5-bit hardware colour
// combinationally. The CPC raster interrupt (52-line counter, VSYNC resync,
// M1 acknowledge) is also generated here.
//
// Ports:
//   clk            system clock, all inputs synchronous to it
//   n_reset        asynchronous active-low reset
//   cpu_addr       Z80 address bus
//   cpu_dout       Z80 data out
//   n_iorq/n_wr    Z80 IORQ / WR strobes, active low
//   n_m1           Z80 M1, active low (with IORQ = interrupt acknowledge)
//   vga_hs/vga_vs  video hsync / vsync, active low
//   pen            pen index from the video generator
//   color          hardware colour of pen (combinational)
//   border_color   border hardware colour
//   mode           screen mode, updated on hsync fall only
//   lower_rom_dis  lower ROM disable
//   upper_rom_dis  upper ROM disable
//   n_int          interrupt request to the Z80, active low
//
// Handshake: a CPU write is accepted once, on the first cycle the decoded
// write strobe is seen high; it must drop before another write is taken.
module ga_palette_regs #(
   parameter int LINE_DIV  = 2,
   parameter int INT_LINES = 52,
   parameter int RESET_INK = 20
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        n_iorq,
   input  logic        n_wr,
   input  logic        n_m1,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic [3:0]  pen,
   output logic [4:0]  color,
   output logic [4:0]  border_color,
   output logic [1:0]  mode,
   output logic        lower_rom_dis,
   output logic        upper_rom_dis,
   output logic        n_int
);

   localparam int              DIV_W    = (LINE_DIV > 1) ? $clog2(LINE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LINE_DIV - 1);
   localparam logic [5:0]       LC_LAST  = 6'(INT_LINES - 1);
   localparam logic [4:0]       INK_RST  = 5'(RESET_INK);

   logic [4:0]       ink_q [16];
   logic [4:0]       ink_d [16];
   logic [4:0]       border_q, border_d;
   logic [3:0]       pen_sel_q, pen_sel_d;
   logic             border_sel_q, border_sel_d;
   logic [1:0]       mode_q, mode_d;
   logic [1:0]       pend_mode_q, pend_mode_d;
   logic             lrom_q, lrom_d;
   logic             urom_q, urom_d;
   logic [5:0]       lc_q, lc_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       vs_dly_q, vs_dly_d;
   logic             n_int_q, n_int_d;
   logic             wr_act_q, ack_q, hs_q, vs_q;

   logic       wr_act, wr_stb, ack_act, ack_stb;
   logic       hs_fall, vs_fall, tick, resync, f10_clr, int_set;
   logic [1:0] fn;

   // Address bits below A14 and data bit 5 do not take part in decoding.
   logic unused_bits;
   assign unused_bits = ^{cpu_addr[13:0], cpu_dout[5]};

   assign wr_act  = !n_iorq && !n_wr && !cpu_addr[15] && cpu_addr[14];
   assign wr_stb  = wr_act && !wr_act_q;
   assign fn      = cpu_dout[7:6];
   assign ack_act = !n_m1 && !n_iorq;
   assign ack_stb = ack_act && !ack_q;
   assign hs_fall = hs_q && !vga_hs;
   assign vs_fall = vs_q && !vga_vs;
   assign tick    = hs_fall && (div_q == DIV_LAST);
   // The delay expires on its second tick; a new vsync edge in that same
   // cycle restarts it instead.
   assign resync  = tick && (vs_dly_q == 2'd1) && !vs_fall;
   assign f10_clr = wr_stb && (fn == 2'b10) && cpu_dout[4];
   assign int_set = tick && (resync ? lc_q[5] : (lc_q == LC_LAST));

   always_comb begin
      ink_d        = ink_q;
      border_d     = border_q;
      pen_sel_d    = pen_sel_q;
      border_sel_d = border_sel_q;
      mode_d       = mode_q;
      pend_mode_d  = pend_mode_q;
      lrom_d       = lrom_q;
      urom_d       = urom_q;
      div_d        = div_q;
      vs_dly_d     = vs_dly_q;
      lc_d         = lc_q;
      n_int_d      = n_int_q;

      if (wr_stb) begin
         case (fn)
            2'b00: begin
               border_sel_d = cpu_dout[4];
               pen_sel_d    = cpu_dout[3:0];
            end
            2'b01: begin
               if (border_sel_q) border_d = cpu_dout[4:0];
               else              ink_d[pen_sel_q] = cpu_dout[4:0];
            end
            2'b10: begin
               pend_mode_d = cpu_dout[1:0];
               lrom_d      = cpu_dout[2];
               urom_d      = cpu_dout[3];
            end
            default: ;
         endcase
      end

      // Mode samples the pending value held before any same-cycle write.
      if (hs_fall) begin
         mode_d = pend_mode_q;
         div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      end

      if (vs_fall)                          vs_dly_d = 2'd2;
      else if (tick && (vs_dly_q != 2'd0))  vs_dly_d = vs_dly_q - 2'd1;

      // Lowest priority first, later assignments override. Both the set
      // paths and the function-10 clear leave the counter at zero, so the
      // clear only visibly overrides a plain increment or an acknowledge.
      if (ack_stb) lc_d[5] = 1'b0;
      if (tick)    lc_d = (resync || (lc_q == LC_LAST)) ? 6'd0 : lc_q + 6'd1;
      if (f10_clr) lc_d = 6'd0;

      if (ack_stb) n_int_d = 1'b1;
      if (f10_clr) n_int_d = 1'b1;
      if (int_set) n_int_d = 1'b0;
   end

   // Edge-detect history resets to the inactive level so a strobe already
   // asserted when reset is released is not taken as a new access.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 16; i++) ink_q[i] <= INK_RST;
         border_q     <= INK_RST;
         pen_sel_q    <= 4'd0;
         border_sel_q <= 1'b0;
         mode_q       <= 2'd1;
         pend_mode_q  <= 2'd1;
         lrom_q       <= 1'b0;
         urom_q       <= 1'b0;
         lc_q         <= 6'd0;
         div_q        <= '0;
         vs_dly_q     <= 2'd0;
         n_int_q      <= 1'b1;
         wr_act_q     <= 1'b1;
         ack_q        <= 1'b1;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
      end else begin
         ink_q        <= ink_d;
         border_q     <= border_d;
         pen_sel_q    <= pen_sel_d;
         border_sel_q <= border_sel_d;
         mode_q       <= mode_d;
         pend_mode_q  <= pend_mode_d;
         lrom_q       <= lrom_d;
         urom_q       <= urom_d;
         lc_q         <= lc_d;
         div_q        <= div_d;
         vs_dly_q     <= vs_dly_d;
         n_int_q      <= n_int_d;
         wr_act_q     <= wr_act;
         ack_q        <= ack_act;
         hs_q         <= vga_hs;
         vs_q         <= vga_vs;
      end
   end

   assign color         = ink_q[pen];
   assign border_color  = border_q;
   assign mode          = mode_q;
   assign lower_rom_dis = lrom_q;
   assign upper_rom_dis = urom_q;
   assign n_int         = n_int_q;

endmodule

// File: tb/tb_ga_palette_regs.sv
// tb_ga_palette_regs - self-checking bench for ga_palette_regs.
// Register state is tracked by a behavioural array model; interrupt timing
// is checked as counts of hsync pulses between interrupts.
module tb_ga_palette_regs;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        n_iorq, n_wr, n_m1, vga_hs, vga_vs;
   logic [3:0]  pen;
   logic [4:0]  color, border_color;
   logic [1:0]  mode;
   logic        lower_rom_dis, upper_rom_dis, n_int;

   int n_checks = 0;
   int n_errors = 0;

   ga_palette_regs dut (
      .clk(clk), .n_reset(n_reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
      .n_iorq(n_iorq), .n_wr(n_wr), .n_m1(n_m1), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .pen(pen), .color(color), .border_color(border_color), .mode(mode),
      .lower_rom_dis(lower_rom_dis), .upper_rom_dis(upper_rom_dis), .n_int(n_int)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [4:0] ink_m [16];
   logic [4:0] border_m;
   logic [3:0] psel_m;
   logic       bsel_m;
   logic [1:0] pend_m, mode_m;
   logic       lrom_m, urom_m;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) ink_m[i] = 5'd20;
      border_m = 5'd20; psel_m = 4'd0; bsel_m = 1'b0;
      pend_m = 2'd1; mode_m = 2'd1; lrom_m = 1'b0; urom_m = 1'b0;
   endtask

   task automatic model_write(input logic [15:0] a, input logic [7:0] d);
      if (a[15] == 1'b0 && a[14] == 1'b1) begin
         case (d[7:6])
            2'b00: begin bsel_m = d[4]; psel_m = d[3:0]; end
            2'b01: if (bsel_m) border_m = d[4:0]; else ink_m[psel_m] = d[4:0];
            2'b10: begin pend_m = d[1:0]; lrom_m = d[2]; urom_m = d[3]; end
            default: ;
         endcase
      end
   endtask

   // ---------------- drivers ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic io_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_dout = d; n_iorq = 1'b0; n_wr = 1'b0;
      cyc();
      model_write(a, d);
      n_iorq = 1'b1; n_wr = 1'b1;
      cyc();
   endtask

   task automatic hs_pulse();
      vga_hs = 1'b0;
      cyc();
      mode_m = pend_m;
      vga_hs = 1'b1;
      cyc();
   endtask

   task automatic vs_pulse();
      vga_vs = 1'b0; cyc(); vga_vs = 1'b1; cyc();
   endtask

   task automatic do_ack();
      n_m1 = 1'b0; n_iorq = 1'b0; cyc(); n_m1 = 1'b1; n_iorq = 1'b1; cyc();
   endtask

   // Called just after a posedge; reset is released on the falling edge.
   task automatic do_reset();
      n_reset = 1'b0; #4; n_reset = 1'b1;
      model_reset();
      cyc();
   endtask

   // Counts hsync pulses until n_int goes low (bounded).
   task automatic count_to_int(output int n);
      n = 0;
      while (n < 300 && n_int !== 1'b0) begin
         hs_pulse();
         n++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int p = 0; p < 16; p++) begin
         pen = 4'(p); #1;
         n_checks++;
         if (color !== 5'd20) begin
            n_errors++; $display("FAIL reset_color pen=%0d got=%0d exp=20", p, color);
         end
      end
      n_checks++;
      if (border_color !== 5'd20) begin n_errors++; $display("FAIL reset_border got=%0d exp=20", border_color); end
      n_checks++;
      if (mode !== 2'd1) begin n_errors++; $display("FAIL reset_mode got=%0d exp=1", mode); end
      n_checks++;
      if (n_int !== 1'b1) begin n_errors++; $display("FAIL reset_n_int got=%b exp=1", n_int); end
      n_checks++;
      if ({lower_rom_dis, upper_rom_dis} !== 2'b00) begin
         n_errors++; $display("FAIL reset_rom got=%b%b exp=00", lower_rom_dis, upper_rom_dis);
      end
   endtask

   task automatic test_ink();
      io_write(16'h7F00, 8'h05);
      io_write(16'h7F00, 8'h4C);
      for (int p = 0; p < 16; p++) begin
         pen = 4'(p); #1;
         n_checks++;
         if (color !== ((p == 5) ? 5'd12 : 5'd20)) begin
            n_errors++; $display("FAIL ink_write pen=%0d got=%0d exp=%0d", p, color, (p == 5) ? 12 : 20);
         end
      end
      io_write(16'h7F00, 8'h10);
      io_write(16'h7F00, 8'h54);
      pen = 4'd0; #1;
      n_checks++;
      if (border_color !== 5'h14) begin n_errors++; $display("FAIL border_write got=%0d exp=20", border_color); end
      n_checks++;
      if (color !== 5'd20) begin n_errors++; $display("FAIL border_ink0 got=%0d exp=20", color); end
   endtask

   task automatic test_mode();
      io_write(16'h7F00, 8'h8E);
      n_checks++;
      if (upper_rom_dis !== 1'b1 || lower_rom_dis !== 1'b1) begin
         n_errors++; $display("FAIL rom_bits got=%b%b exp=11", lower_rom_dis, upper_rom_dis);
      end
      n_checks++;
      if (mode !== 2'd1) begin n_errors++; $display("FAIL mode_midline got=%0d exp=1", mode); end
      vga_hs = 1'b0; #3;
      n_checks++;
      if (mode !== 2'd1) begin n_errors++; $display("FAIL mode_before_edge got=%0d exp=1", mode); end
      cyc();
      n_checks++;
      if (mode !== 2'd2) begin n_errors++; $display("FAIL mode_after_hs got=%0d exp=2", mode); end
      vga_hs = 1'b1; cyc();
   endtask

   task automatic test_int_period();
      int n;
      do_reset();
      count_to_int(n);
      n_checks++;
      if (n !== 104) begin n_errors++; $display("FAIL int_first got=%0d hs exp=104", n); end
      n_m1 = 1'b0; n_iorq = 1'b0; cyc();
      n_checks++;
      if (n_int !== 1'b1) begin n_errors++; $display("FAIL int_ack got=%b exp=1", n_int); end
      n_m1 = 1'b1; n_iorq = 1'b1; cyc();
      count_to_int(n);
      n_checks++;
      if (n !== 104) begin n_errors++; $display("FAIL int_period got=%0d hs exp=104", n); end
      do_ack();
   endtask

   task automatic test_resync();
      int n;
      // counter at 40: resync raises an interrupt
      do_reset();
      repeat (80) hs_pulse();
      vs_pulse();
      repeat (3) hs_pulse();
      n_checks++;
      if (n_int !== 1'b1) begin n_errors++; $display("FAIL resync_early got=%b exp=1", n_int); end
      hs_pulse();
      n_checks++;
      if (n_int !== 1'b0) begin n_errors++; $display("FAIL resync40_int got=%b exp=0", n_int); end
      do_ack();
      count_to_int(n);
      n_checks++;
      if (n !== 104) begin n_errors++; $display("FAIL resync40_cnt got=%0d hs exp=104", n); end
      // counter at 10: no interrupt, counter still zeroed
      do_reset();
      repeat (20) hs_pulse();
      vs_pulse();
      repeat (4) hs_pulse();
      n_checks++;
      if (n_int !== 1'b1) begin n_errors++; $display("FAIL resync10_int got=%b exp=1", n_int); end
      count_to_int(n);
      n_checks++;
      if (n !== 104) begin n_errors++; $display("FAIL resync10_cnt got=%0d hs exp=104", n); end
      // re-arm restarts the 2-tick delay
      do_reset();
      repeat (80) hs_pulse();
      vs_pulse();
      repeat (2) hs_pulse();
      vs_pulse();
      repeat (2) hs_pulse();
      n_checks++;
      if (n_int !== 1'b1) begin n_errors++; $display("FAIL rearm_early got=%b exp=1", n_int); end
      repeat (2) hs_pulse();
      n_checks++;
      if (n_int !== 1'b0) begin n_errors++; $display("FAIL rearm_int got=%b exp=0", n_int); end
      do_ack();
   endtask

   task automatic test_hold_write();
      do_reset();
      io_write(16'h7F00, 8'h03);
      cpu_addr = 16'h7F00; cpu_dout = 8'h4C; n_iorq = 1'b0; n_wr = 1'b0;
      cyc();
      cpu_dout = 8'h55;
      repeat (4) cyc();
      n_iorq = 1'b1; n_wr = 1'b1; cyc();
      pen = 4'd3; #1;
      n_checks++;
      if (color !== 5'd12) begin n_errors++; $display("FAIL hold_write got=%0d exp=12", color); end
      // reset during an asserted write strobe: nothing is written
      cpu_dout = 8'h4C; n_iorq = 1'b0; n_wr = 1'b0;
      do_reset();
      repeat (3) cyc();
      n_iorq = 1'b1; n_wr = 1'b1; cyc();
      pen = 4'd0; #1;
      n_checks++;
      if (color !== 5'd20) begin n_errors++; $display("FAIL reset_abort got=%0d exp=20", color); end
      pen = 4'd3; #1;
      n_checks++;
      if (color !== 5'd20) begin n_errors++; $display("FAIL reset_ink3 got=%0d exp=20", color); end
   endtask

   task automatic test_set_vs_clear();
      int n;
      do_reset();
      repeat (103) hs_pulse();
      cpu_addr = 16'h7F00; cpu_dout = 8'h90; n_iorq = 1'b0; n_wr = 1'b0; vga_hs = 1'b0;
      cyc();
      mode_m = pend_m;
      model_write(16'h7F00, 8'h90);
      n_checks++;
      if (n_int !== 1'b0) begin n_errors++; $display("FAIL set_beats_clear got=%b exp=0", n_int); end
      n_iorq = 1'b1; n_wr = 1'b1; vga_hs = 1'b1; cyc();
      do_ack();
      count_to_int(n);
      n_checks++;
      if (n !== 104) begin n_errors++; $display("FAIL set_clear_cnt got=%0d hs exp=104", n); end
      // plain function-10 clear of a pending interrupt
      io_write(16'h7F00, 8'h90);
      n_checks++;
      if (n_int !== 1'b1) begin n_errors++; $display("FAIL f10_clear got=%b exp=1", n_int); end
      count_to_int(n);
      n_checks++;
      if (n !== 104) begin n_errors++; $display("FAIL f10_clear_cnt got=%0d hs exp=104", n); end
      do_ack();
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [7:0]  d;
      do_reset();
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            hs_pulse();
         end else begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[15:14] = 2'b01;
            d = 8'($urandom);
            io_write(a, d);
         end
         pen = 4'($urandom_range(0, 15)); #1;
         n_checks++;
         if (color !== ink_m[pen]) begin
            n_errors++; $display("FAIL rnd_color it=%0d pen=%0d got=%0d exp=%0d", it, pen, color, ink_m[pen]);
         end
         n_checks++;
         if (border_color !== border_m || mode !== mode_m ||
             lower_rom_dis !== lrom_m || upper_rom_dis !== urom_m) begin
            n_errors++;
            $display("FAIL rnd_regs it=%0d got=%0d/%0d/%b%b exp=%0d/%0d/%b%b", it,
                     border_color, mode, lower_rom_dis, upper_rom_dis,
                     border_m, mode_m, lrom_m, urom_m);
         end
      end
   endtask

   initial begin
      n_reset = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
      n_iorq = 1'b1; n_wr = 1'b1; n_m1 = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; pen = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      test_reset();
      test_ink();
      test_mode();
      test_int_period();
      test_resync();
      test_hold_write();
      test_set_vs_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
